// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds signed operands from key edges, drives
// arithmetic-unit load/compute strobes and selects entry or result display.
module calc_sequencer #(
   parameter int unsigned MAX_MAG     = 127,
   parameter int unsigned RESULT_WAIT = 1
) (
   input  logic       i_CLOCK,
   input  logic       i_RESET_N,
   input  logic       i_CLEAR_ALL,
   input  logic       i_CLEAR_ENTRY,
   input  logic       i_KEY_VALID,
   input  logic [3:0] i_KEY_CODE,
   input  logic [7:0] i_AU_RESULT,
   output logic [7:0] o_OPERAND,
   output logic       o_LOAD_A,
   output logic       o_LOAD_B,
   output logic       o_ADD_SUB,
   output logic       o_LOAD_R,
   output logic       o_AU_CLEAR,
   output logic       o_SHOW_RESULT,
   output logic       o_OVERFLOW,
   output logic       o_KEY_REJECT,
   output logic [3:0] o_STATE
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned MAG_W  = 8;
   localparam int unsigned PROD_W = 12;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [3:0] {
      ENTER_A = 4'd0,
      LOAD_A  = 4'd1,
      ENTER_B = 4'd2,
      LOAD_B  = 4'd3,
      COMPUTE = 4'd4,
      SHOW    = 4'd5
   } state_t;

   state_t              state_q, state_d;
   logic [MAG_W-1:0]    mag_q, mag_d;
   logic                sign_q, sign_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
   logic                add_sub_q, add_sub_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                key_prev_q, key_prev_d;
   logic                ovf_q, ovf_d;
   logic                reject_q, reject_d;
   logic                au_clear_q, au_clear_d;
   logic [DATA_W-1:0]   operand_q;
   logic                load_a_q, load_b_q, load_r_q, show_q;

   logic                key_edge, is_digit, digit_ok, first_ok, ovf_calc;
   logic [PROD_W-1:0]   entry_prod;
   logic [MAG_W-1:0]    res_abs, res_mag;

   // Two's-complement value of a sign/magnitude entry
   function automatic logic [DATA_W-1:0] operand_of(input logic [MAG_W-1:0] m, input logic s);
      return s ? (DATA_W'(0) - DATA_W'(m)) : DATA_W'(m);
   endfunction

   // Key edge detect, digit accumulation limits, chained-result magnitude, overflow
   assign key_edge   = i_KEY_VALID & ~key_prev_q;
   assign is_digit   = (i_KEY_CODE <= 4'd9);
   assign entry_prod = PROD_W'(mag_q) * PROD_W'(10) + PROD_W'(i_KEY_CODE);
   assign digit_ok   = (entry_prod <= PROD_W'(MAX_MAG));
   assign first_ok   = (PROD_W'(i_KEY_CODE) <= PROD_W'(MAX_MAG));
   assign res_abs    = result_q[7] ? (MAG_W'(0) - result_q) : result_q;
   assign res_mag    = (PROD_W'(res_abs) > PROD_W'(MAX_MAG)) ? MAG_W'(MAX_MAG) : res_abs;
   assign ovf_calc   = add_sub_q ? ((op_a_q[7] != op_b_q[7]) && (i_AU_RESULT[7] != op_a_q[7]))
                                 : ((op_a_q[7] == op_b_q[7]) && (i_AU_RESULT[7] != op_a_q[7]));

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      sign_d     = sign_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      result_d   = result_q;
      add_sub_d  = add_sub_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      reject_d   = 1'b0;
      au_clear_d = 1'b0;
      key_prev_d = i_KEY_VALID;

      if (i_CLEAR_ALL) begin
         state_d    = ENTER_A;
         mag_d      = '0;
         sign_d     = 1'b0;
         op_a_d     = '0;
         op_b_d     = '0;
         result_d   = '0;
         add_sub_d  = 1'b0;
         cnt_d      = '0;
         ovf_d      = 1'b0;
         au_clear_d = 1'b1;
         key_prev_d = 1'b1;
      end else begin
         case (state_q)
            ENTER_A, ENTER_B: begin
               if (i_CLEAR_ENTRY) begin
                  mag_d  = '0;
                  sign_d = 1'b0;
               end else if (key_edge) begin
                  if (is_digit) begin
                     if (digit_ok) mag_d = MAG_W'(entry_prod);
                     else          reject_d = 1'b1;
                  end else begin
                     case (i_KEY_CODE)
                        4'hA, 4'hB: begin
                           add_sub_d = i_KEY_CODE[0];
                           if (state_q == ENTER_A) state_d = LOAD_A;
                        end
                        4'hC: begin
                           if (state_q == ENTER_A) reject_d = 1'b1;
                           else                    state_d  = LOAD_B;
                        end
                        4'hD:    sign_d = ~sign_q;
                        default: ;
                     endcase
                  end
               end
            end
            LOAD_A: begin
               op_a_d   = operand_of(mag_q, sign_q);
               mag_d    = '0;
               sign_d   = 1'b0;
               state_d  = ENTER_B;
               reject_d = key_edge;
            end
            LOAD_B: begin
               op_b_d   = operand_of(mag_q, sign_q);
               cnt_d    = '0;
               state_d  = COMPUTE;
               reject_d = key_edge;
            end
            COMPUTE: begin
               reject_d = key_edge;
               if (cnt_q == CNT_W'(RESULT_WAIT - 1)) begin
                  result_d = i_AU_RESULT;
                  ovf_d    = ovf_calc;
                  state_d  = SHOW;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            SHOW: begin
               if (i_CLEAR_ENTRY) begin
                  mag_d   = '0;
                  sign_d  = 1'b0;
                  ovf_d   = 1'b0;
                  state_d = ENTER_A;
               end else if (key_edge) begin
                  if (is_digit) begin
                     mag_d    = first_ok ? MAG_W'(i_KEY_CODE) : '0;
                     reject_d = ~first_ok;
                     sign_d   = 1'b0;
                     ovf_d    = 1'b0;
                     state_d  = ENTER_A;
                  end else if (i_KEY_CODE == 4'hA || i_KEY_CODE == 4'hB) begin
                     add_sub_d = i_KEY_CODE[0];
                     mag_d     = res_mag;
                     sign_d    = result_q[7];
                     ovf_d     = 1'b0;
                     state_d   = LOAD_A;
                  end
               end
            end
            default: begin
               ovf_d   = 1'b0;
               state_d = ENTER_A;
            end
         endcase
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge i_CLOCK) begin
      if (!i_RESET_N) begin
         state_q    <= ENTER_A;
         mag_q      <= '0;
         sign_q     <= 1'b0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         result_q   <= '0;
         add_sub_q  <= 1'b0;
         cnt_q      <= '0;
         key_prev_q <= 1'b1;
         ovf_q      <= 1'b0;
         reject_q   <= 1'b0;
         au_clear_q <= 1'b1;
         operand_q  <= '0;
         load_a_q   <= 1'b0;
         load_b_q   <= 1'b0;
         load_r_q   <= 1'b0;
         show_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         sign_q     <= sign_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         result_q   <= result_d;
         add_sub_q  <= add_sub_d;
         cnt_q      <= cnt_d;
         key_prev_q <= key_prev_d;
         ovf_q      <= ovf_d;
         reject_q   <= reject_d;
         au_clear_q <= au_clear_d;
         operand_q  <= operand_of(mag_d, sign_d);
         load_a_q   <= (state_d == LOAD_A);
         load_b_q   <= (state_d == LOAD_B);
         load_r_q   <= (state_d == COMPUTE);
         show_q     <= (state_d == SHOW);
      end
   end

   assign o_OPERAND     = operand_q;
   assign o_LOAD_A      = load_a_q;
   assign o_LOAD_B      = load_b_q;
   assign o_ADD_SUB     = add_sub_q;
   assign o_LOAD_R      = load_r_q;
   assign o_AU_CLEAR    = au_clear_q;
   assign o_SHOW_RESULT = show_q;
   assign o_OVERFLOW    = ovf_q;
   assign o_KEY_REJECT  = reject_q;
   assign o_STATE       = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: keypad sequences, AU model,
// operand scoreboard and a second instance with a longer result wait.
module tb_calc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n, clear_all, clear_entry, key_valid;
   logic [3:0] key_code;
   logic [7:0] au_result, operand;
   logic       load_a, load_b, add_sub, load_r, au_clear, show, ovf, reject;
   logic [3:0] state;

   logic       rst_n4, clear_all4, clear_entry4, key_valid4;
   logic [3:0] key_code4;
   logic [7:0] au_result4, operand4;
   logic       load_a4, load_b4, add_sub4, load_r4, au_clear4, show4, ovf4, reject4;
   logic [3:0] state4;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic       is_b;
      logic [7:0] val;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   logic [7:0] au_a = 8'd0;
   logic [7:0] au_b = 8'd0;

   always #5 clk = ~clk;

   calc_sequencer dut (
      .i_CLOCK(clk), .i_RESET_N(rst_n), .i_CLEAR_ALL(clear_all), .i_CLEAR_ENTRY(clear_entry),
      .i_KEY_VALID(key_valid), .i_KEY_CODE(key_code), .i_AU_RESULT(au_result),
      .o_OPERAND(operand), .o_LOAD_A(load_a), .o_LOAD_B(load_b), .o_ADD_SUB(add_sub),
      .o_LOAD_R(load_r), .o_AU_CLEAR(au_clear), .o_SHOW_RESULT(show), .o_OVERFLOW(ovf),
      .o_KEY_REJECT(reject), .o_STATE(state)
   );

   calc_sequencer #(.MAX_MAG(127), .RESULT_WAIT(4)) dut4 (
      .i_CLOCK(clk), .i_RESET_N(rst_n4), .i_CLEAR_ALL(clear_all4), .i_CLEAR_ENTRY(clear_entry4),
      .i_KEY_VALID(key_valid4), .i_KEY_CODE(key_code4), .i_AU_RESULT(au_result4),
      .o_OPERAND(operand4), .o_LOAD_A(load_a4), .o_LOAD_B(load_b4), .o_ADD_SUB(add_sub4),
      .o_LOAD_R(load_r4), .o_AU_CLEAR(au_clear4), .o_SHOW_RESULT(show4), .o_OVERFLOW(ovf4),
      .o_KEY_REJECT(reject4), .o_STATE(state4)
   );

   // Arithmetic-unit model for the main instance
   always @(posedge clk) begin
      if (load_a) au_a <= operand;
      if (load_b) au_b <= operand;
   end
   assign au_result  = add_sub ? (au_a - au_b) : (au_a + au_b);
   assign au_result4 = 8'h11;

   // Scoreboard: every load strobe must match the next expected operand
   always @(negedge clk) begin
      if (rst_n && (load_a || load_b)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_load: got load_a=%0b load_b=%0b operand=%h, expected no load", load_a, load_b, operand);
         end else begin
            mon_e = exp_q.pop_front();
            if (load_b !== mon_e.is_b || operand !== mon_e.val) begin
               errors++;
               $display("FAIL scoreboard_load: got load_b=%0b operand=%h, expected load_b=%0b operand=%h",
                        load_b, operand, mon_e.is_b, mon_e.val);
            end
         end
      end
   end

   function automatic logic ovf_model(input int a, input int b, input bit sub);
      int r;
      r = sub ? (a - b) : (a + b);
      return (r > 127) || (r < -128);
   endfunction

   function automatic exp_t mk(input logic is_b, input logic [7:0] v);
      exp_t e;
      e.is_b = is_b;
      e.val  = v;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key_down(input logic [3:0] c);
      key_valid = 1'b1;
      key_code  = c;
      step();
   endtask

   task automatic key_up();
      key_valid = 1'b0;
      step();
   endtask

   task automatic press(input logic [3:0] c);
      key_down(c);
      key_up();
   endtask

   task automatic key_down4(input logic [3:0] c);
      key_valid4 = 1'b1;
      key_code4  = c;
      step();
   endtask

   task automatic press4(input logic [3:0] c);
      key_down4(c);
      key_valid4 = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_n4 = 1'b0;
      key_valid = 1'b1; key_code = 4'd7;
      step(); step();
      checks++;
      if (state !== 4'd0 || au_clear !== 1'b1 || operand !== 8'h00) begin
         errors++;
         $display("FAIL reset_state: got state=%0d au_clear=%0b operand=%h, expected 0 1 00", state, au_clear, operand);
      end
      checks++;
      if ({load_a, load_b, load_r, show, ovf, reject, add_sub} !== 7'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b, expected 0000000", {load_a, load_b, load_r, show, ovf, reject, add_sub});
      end
      checks++;
      if (state4 !== 4'd0 || au_clear4 !== 1'b1) begin
         errors++;
         $display("FAIL reset_state4: got state=%0d au_clear=%0b, expected 0 1", state4, au_clear4);
      end
      rst_n = 1'b1; rst_n4 = 1'b1;
      step(); step(); step();
      checks++;
      if (operand !== 8'h00 || au_clear !== 1'b0 || reject !== 1'b0) begin
         errors++;
         $display("FAIL reset_held_key: got operand=%h au_clear=%0b reject=%0b, expected 00 0 0", operand, au_clear, reject);
      end
      key_up();
   endtask

   task automatic test_basic();
      exp_q.push_back(mk(1'b0, 8'd12));
      exp_q.push_back(mk(1'b1, 8'd3));
      press(4'd1); press(4'd2);
      checks++;
      if (operand !== 8'd12) begin
         errors++;
         $display("FAIL basic_entry: got operand=%0d, expected 12", operand);
      end
      key_down(4'hA);
      checks++;
      if (state !== 4'd1 || load_a !== 1'b1 || operand !== 8'd12 || add_sub !== 1'b0) begin
         errors++;
         $display("FAIL basic_load_a: got state=%0d load_a=%0b operand=%0d add_sub=%0b, expected 1 1 12 0", state, load_a, operand, add_sub);
      end
      key_up();
      checks++;
      if (state !== 4'd2 || load_a !== 1'b0 || operand !== 8'd0) begin
         errors++;
         $display("FAIL basic_enter_b: got state=%0d load_a=%0b operand=%0d, expected 2 0 0", state, load_a, operand);
      end
      press(4'd3);
      key_down(4'hC);
      checks++;
      if (state !== 4'd3 || load_b !== 1'b1 || operand !== 8'd3) begin
         errors++;
         $display("FAIL basic_load_b: got state=%0d load_b=%0b operand=%0d, expected 3 1 3", state, load_b, operand);
      end
      key_up();
      checks++;
      if (state !== 4'd4 || load_r !== 1'b1 || load_b !== 1'b0) begin
         errors++;
         $display("FAIL basic_compute: got state=%0d load_r=%0b load_b=%0b, expected 4 1 0", state, load_r, load_b);
      end
      step();
      checks++;
      if (state !== 4'd5 || load_r !== 1'b0 || show !== 1'b1 || ovf !== ovf_model(12, 3, 1'b0)) begin
         errors++;
         $display("FAIL basic_show: got state=%0d load_r=%0b show=%0b ovf=%0b, expected 5 0 1 %0b", state, load_r, show, ovf, ovf_model(12, 3, 1'b0));
      end
   endtask

   task automatic test_entry();
      clear_entry = 1'b1; step(); clear_entry = 1'b0;
      checks++;
      if (state !== 4'd0 || show !== 1'b0 || operand !== 8'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL entry_clear_show: got state=%0d show=%0b operand=%h ovf=%0b, expected 0 0 00 0", state, show, operand, ovf);
      end
      press(4'd1); press(4'd2);
      key_down(4'd8);
      checks++;
      if (reject !== 1'b1 || operand !== 8'd12) begin
         errors++;
         $display("FAIL entry_limit: got reject=%0b operand=%0d, expected 1 12", reject, operand);
      end
      key_up();
      checks++;
      if (reject !== 1'b0) begin
         errors++;
         $display("FAIL entry_reject_pulse: got reject=%0b, expected 0", reject);
      end
      key_down(4'hC);
      checks++;
      if (reject !== 1'b1 || state !== 4'd0) begin
         errors++;
         $display("FAIL entry_equals_in_a: got reject=%0b state=%0d, expected 1 0", reject, state);
      end
      key_up();
      key_down(4'hE);
      checks++;
      if (reject !== 1'b0 || state !== 4'd0 || operand !== 8'd12) begin
         errors++;
         $display("FAIL entry_ignored_key: got reject=%0b state=%0d operand=%0d, expected 0 0 12", reject, state, operand);
      end
      key_up();
      clear_entry = 1'b1; step(); clear_entry = 1'b0;
      press(4'd5); press(4'hD);
      checks++;
      if (operand !== 8'hFB) begin
         errors++;
         $display("FAIL entry_negate: got operand=%h, expected fb", operand);
      end
      press(4'hD);
      checks++;
      if (operand !== 8'h05) begin
         errors++;
         $display("FAIL entry_negate_back: got operand=%h, expected 05", operand);
      end
      clear_entry = 1'b1;
      key_down(4'd9);
      clear_entry = 1'b0;
      checks++;
      if (operand !== 8'h00) begin
         errors++;
         $display("FAIL entry_clear_priority: got operand=%h, expected 00", operand);
      end
      key_up();
   endtask

   task automatic test_overflow_chain();
      exp_q.push_back(mk(1'b0, 8'd100));
      exp_q.push_back(mk(1'b1, 8'd50));
      press(4'd1); press(4'd0); press(4'd0);
      press(4'hA);
      press(4'd5); press(4'd0);
      press(4'hC);
      step();
      checks++;
      if (show !== 1'b1 || ovf !== ovf_model(100, 50, 1'b0)) begin
         errors++;
         $display("FAIL ovf_add: got show=%0b ovf=%0b, expected 1 %0b", show, ovf, ovf_model(100, 50, 1'b0));
      end
      exp_q.push_back(mk(1'b0, 8'h96));
      key_down(4'hB);
      checks++;
      if (state !== 4'd1 || load_a !== 1'b1 || operand !== 8'h96 || add_sub !== 1'b1 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL chain_load: got state=%0d load_a=%0b operand=%h add_sub=%0b ovf=%0b, expected 1 1 96 1 0", state, load_a, operand, add_sub, ovf);
      end
      key_up();
   endtask

   task automatic test_saturate();
      clear_all = 1'b1; step(); clear_all = 1'b0; step();
      checks++;
      if (state !== 4'd0 || operand !== 8'd0) begin
         errors++;
         $display("FAIL sat_clear: got state=%0d operand=%h, expected 0 00", state, operand);
      end
      exp_q.push_back(mk(1'b0, 8'h9C));
      exp_q.push_back(mk(1'b1, 8'hE4));
      press(4'd1); press(4'd0); press(4'd0); press(4'hD);
      press(4'hA);
      press(4'd2); press(4'd8); press(4'hD);
      press(4'hC);
      step();
      checks++;
      if (show !== 1'b1 || ovf !== ovf_model(-100, -28, 1'b0)) begin
         errors++;
         $display("FAIL sat_show: got show=%0b ovf=%0b, expected 1 %0b", show, ovf, ovf_model(-100, -28, 1'b0));
      end
      exp_q.push_back(mk(1'b0, 8'h81));
      key_down(4'hA);
      checks++;
      if (load_a !== 1'b1 || operand !== 8'h81 || add_sub !== 1'b0) begin
         errors++;
         $display("FAIL sat_chain: got load_a=%0b operand=%h add_sub=%0b, expected 1 81 0", load_a, operand, add_sub);
      end
      key_up();
   endtask

   task automatic test_clear_all();
      press(4'd7);
      clear_all = 1'b1;
      key_down(4'd3);
      clear_all = 1'b0;
      checks++;
      if (state !== 4'd0 || au_clear !== 1'b1 || operand !== 8'd0 || reject !== 1'b0 || add_sub !== 1'b0) begin
         errors++;
         $display("FAIL clear_all: got state=%0d au_clear=%0b operand=%h reject=%0b add_sub=%0b, expected 0 1 00 0 0",
                  state, au_clear, operand, reject, add_sub);
      end
      step();
      checks++;
      if (au_clear !== 1'b0 || operand !== 8'd0) begin
         errors++;
         $display("FAIL clear_all_release: got au_clear=%0b operand=%h, expected 0 00", au_clear, operand);
      end
      key_up();
   endtask

   task automatic test_held_key();
      int rej = 0;
      key_valid = 1'b1;
      key_code  = 4'd7;
      for (int i = 0; i < 20; i++) begin
         step();
         if (reject === 1'b1) rej++;
      end
      key_up();
      checks++;
      if (operand !== 8'd7 || rej !== 0 || state !== 4'd0) begin
         errors++;
         $display("FAIL held_key: got operand=%0d rejects=%0d state=%0d, expected 7 0 0", operand, rej, state);
      end
   endtask

   task automatic test_compute_wait();
      int lr  = 0;
      int rej = 0;
      press4(4'd2);
      press4(4'hA);
      press4(4'd3);
      key_down4(4'hC);
      checks++;
      if (load_b4 !== 1'b1 || operand4 !== 8'd3) begin
         errors++;
         $display("FAIL wait_load_b: got load_b=%0b operand=%0d, expected 1 3", load_b4, operand4);
      end
      key_valid4 = 1'b0;
      step();
      if (load_r4 === 1'b1) lr++;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin key_valid4 = 1'b1; key_code4 = 4'd5; end
         if (i == 1) key_valid4 = 1'b0;
         step();
         if (load_r4 === 1'b1) lr++;
         if (reject4 === 1'b1) rej++;
      end
      checks++;
      if (lr !== 4 || rej !== 1) begin
         errors++;
         $display("FAIL wait_load_r: got load_r_cycles=%0d rejects=%0d, expected 4 1", lr, rej);
      end
      checks++;
      if (state4 !== 4'd5 || show4 !== 1'b1 || operand4 !== 8'd3) begin
         errors++;
         $display("FAIL wait_show: got state=%0d show=%0b operand=%0d, expected 5 1 3", state4, show4, operand4);
      end
   endtask

   task automatic test_reset_compute();
      press4(4'd4);
      press4(4'hA);
      press4(4'd6);
      press4(4'hC);
      step();
      checks++;
      if (state4 !== 4'd4 || load_r4 !== 1'b1) begin
         errors++;
         $display("FAIL abort_in_compute: got state=%0d load_r=%0b, expected 4 1", state4, load_r4);
      end
      rst_n4 = 1'b0;
      step();
      checks++;
      if (state4 !== 4'd0 || load_r4 !== 1'b0 || show4 !== 1'b0 || au_clear4 !== 1'b1 || operand4 !== 8'd0) begin
         errors++;
         $display("FAIL abort_reset: got state=%0d load_r=%0b show=%0b au_clear=%0b operand=%h, expected 0 0 0 1 00",
                  state4, load_r4, show4, au_clear4, operand4);
      end
      rst_n4 = 1'b1;
      step();
      checks++;
      if (state4 !== 4'd0 || au_clear4 !== 1'b0 || ovf4 !== 1'b0 || load_a4 !== 1'b0 || add_sub4 !== 1'b0) begin
         errors++;
         $display("FAIL abort_release: got state=%0d au_clear=%0b ovf=%0b load_a=%0b add_sub=%0b, expected 0 0 0 0 0",
                  state4, au_clear4, ovf4, load_a4, add_sub4);
      end
   endtask

   initial begin
      rst_n = 1'b0; clear_all = 1'b0; clear_entry = 1'b0; key_valid = 1'b0; key_code = 4'd0;
      rst_n4 = 1'b0; clear_all4 = 1'b0; clear_entry4 = 1'b0; key_valid4 = 1'b0; key_code4 = 4'd0;
      test_reset();
      test_basic();
      test_entry();
      test_overflow_chain();
      test_saturate();
      test_clear_all();
      test_held_key();
      test_compute_wait();
      test_reset_compute();
      step();
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending loads, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
